// File: rtl/i2c_cmd_seq.sv
// Command sequencer in front of the i2c bit/byte engine: one host op in flight, one response per op.
// Optional WAIT watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic       busy,
    output logic       i2c_start,
    output logic [1:0] i2c_mode,
    output logic [7:0] i2c_tx_data,
    input  logic       i2c_done,
    input  logic [7:0] i2c_rx_data,
    input  logic       i2c_nack
);

    localparam logic [1:0] OpRead  = 2'd0;
    localparam logic [1:0] OpWrite = 2'd1;

    typedef enum logic [2:0] {StIdle, StIssue, StArm, StWait, StResp} state_e;

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q, nack_d;
    logic       tout_q, tout_d;
    logic       to_expired;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
`else
    logic unused_params;

    assign to_expired    = 1'b0;
    assign unused_params = ^{TIMEOUT_CYCLES, TO_W};
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tx_d    = tx_q;
        rdata_d = rdata_q;
        nack_d  = nack_q;
        tout_d  = tout_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    mode_d  = cmd_op;
                    tx_d    = cmd_data;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StArm;
            // Done may still be high from the previous op here, so it is not looked at.
            StArm: begin
                state_d = StWait;
`ifdef I2C_SEQ_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            StWait: begin
                if (i2c_done) begin
                    rdata_d = (mode_q == OpRead) ? i2c_rx_data : 8'h00;
                    nack_d  = (mode_q == OpWrite) && i2c_nack;
                    tout_d  = 1'b0;
                    state_d = StResp;
                end else if (to_expired) begin
                    rdata_d = 8'h00;
                    nack_d  = 1'b1;
                    tout_d  = 1'b1;
                    state_d = StResp;
                end else begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            mode_q  <= 2'd0;
            tx_q    <= 8'h00;
            rdata_q <= 8'h00;
            nack_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            tout_q  <= tout_d;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign cmd_ready   = (state_q == StIdle) && !sys_rst;
    assign rsp_valid   = (state_q == StResp);
    assign busy        = (state_q != StIdle);
    assign i2c_start   = (state_q == StIssue);
    assign i2c_mode    = mode_q;
    assign i2c_tx_data = tx_q;
    assign rsp_data    = rdata_q;
    assign rsp_nack    = nack_q;
    assign rsp_timeout = tout_q;

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Scoreboard bench for i2c_cmd_seq: directed ops against a behavioural engine model.
module tb_i2c_cmd_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       rsp_timeout;
    logic       busy;
    logic       i2c_start;
    logic [1:0] i2c_mode;
    logic [7:0] i2c_tx_data;
    logic       i2c_done = 1'b0;
    logic [7:0] i2c_rx_data = 8'h00;
    logic       i2c_nack = 1'b0;

    always #5 sys_clk = ~sys_clk;

    i2c_cmd_seq #(
        .TIMEOUT_CYCLES(100),
        .TO_W(16)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .i2c_start(i2c_start),
        .i2c_mode(i2c_mode),
        .i2c_tx_data(i2c_tx_data),
        .i2c_done(i2c_done),
        .i2c_rx_data(i2c_rx_data),
        .i2c_nack(i2c_nack)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine model: done is a level that drops once a new op is under way.
    logic       e_busy = 1'b0;
    int         e_cnt = 0;
    int         e_delay = 10;
    logic       e_stale_hold = 1'b0;
    logic       e_never = 1'b0;
    logic [7:0] e_rx_next = 8'h00;
    logic       e_nack_next = 1'b0;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            e_busy   <= 1'b0;
            e_cnt    <= 0;
            i2c_done <= 1'b0;
        end else if (i2c_start) begin
            e_busy <= 1'b1;
            e_cnt  <= 0;
            if (!e_stale_hold) i2c_done <= 1'b0;
        end else if (e_busy) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt == 0) i2c_done <= 1'b0;
            if (!e_never && e_cnt == e_delay - 1) begin
                i2c_done    <= 1'b1;
                i2c_rx_data <= e_rx_next;
                i2c_nack    <= e_nack_next;
                e_busy      <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] rdata;
        logic       nack;
        logic       tout;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         starts = 0;
    logic [1:0] seen_mode = 2'd0;
    logic [7:0] seen_tx = 8'h00;
    logic       unstable = 1'b0;
    int         rsp_cyc = 0;
    int         hs_cyc = 0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            starts   = 0;
            unstable = 1'b0;
        end else begin
            if (i2c_start) begin
                starts++;
                seen_mode = i2c_mode;
                seen_tx   = i2c_tx_data;
            end else if (busy && starts > 0 && !rsp_valid &&
                         (i2c_mode !== seen_mode || i2c_tx_data !== seen_tx)) begin
                unstable = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got response data %0h, required none", rsp_data);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e.rdata));
                    check("rsp_nack", 32'(rsp_nack), 32'(e.nack));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.tout));
                    check("start_pulses", 32'(starts), 32'd1);
                    check("engine_mode", 32'(seen_mode), 32'(e.op));
                    check("engine_tx", 32'(seen_tx), 32'(e.data));
                    check("mode_tx_stable", 32'(unstable), 32'd0);
                    starts   = 0;
                    unstable = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] data, input logic [7:0] rdata,
                        input logic nack, input logic tout);
        int   n;
        exp_t x;
        x = '{op, data, rdata, nack, tout};
        sb.push_back(x);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!cmd_ready && n < 300);
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready still 0 after %0d cycles, required 1", n);
        end
        hs_cyc = cyc;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_data  = ~data;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max) begin
            @(negedge sys_clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs_first;

        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_start", 32'(i2c_start), 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_mode", 32'(i2c_mode), 32'd0);
        check("idle_tx", 32'(i2c_tx_data), 32'd0);
        check("idle_rsp", 32'({rsp_data, rsp_nack, rsp_timeout}), 32'd0);
        @(posedge sys_clk);
        #1;

        // START / WRITE A5 / STOP, engine done after 10 cycles
        e_delay = 10;
        send(2'd2, 8'h11, 8'h00, 1'b0, 1'b0);
        drain(200);
        send(2'd1, 8'hA5, 8'h00, 1'b0, 1'b0);
        drain(200);
        send(2'd3, 8'h00, 8'h00, 1'b0, 1'b0);
        drain(200);

        // READ returns engine byte; engine nack is ignored for READ
        e_rx_next   = 8'h3C;
        e_nack_next = 1'b1;
        send(2'd0, 8'hEE, 8'h3C, 1'b0, 1'b0);
        drain(200);

        // WRITE with NACK, then STOP still goes out normally
        e_rx_next = 8'h99;
        send(2'd1, 8'h50, 8'h00, 1'b1, 1'b0);
        drain(200);
        e_nack_next = 1'b0;
        send(2'd3, 8'h00, 8'h00, 1'b0, 1'b0);
        drain(200);

        // Zero-latency engine: 4-cycle response latency and 5-cycle back-to-back spacing
        e_delay = 1;
        send(2'd1, 8'h12, 8'h00, 1'b0, 1'b0);
        hs_first = hs_cyc;
        send(2'd1, 8'h34, 8'h00, 1'b0, 1'b0);
        check("back_to_back", 32'(hs_cyc - hs_first), 32'd5);
        drain(50);
        check("min_latency", 32'(rsp_cyc - hs_cyc), 32'd4);

        // Stale done held through ARM must not complete the new op
        e_stale_hold = 1'b1;
        e_delay      = 3;
        e_rx_next    = 8'h77;
        send(2'd0, 8'h00, 8'h77, 1'b0, 1'b0);
        drain(50);
        check("stale_done_latency", 32'(rsp_cyc - hs_cyc), 32'd6);
        e_stale_hold = 1'b0;

        // Response back-pressure for 20 cycles
        e_delay   = 4;
        e_rx_next = 8'h5A;
        rsp_ready = 1'b0;
        send(2'd0, 8'h00, 8'h5A, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!rsp_valid && n < 100);
        for (int i = 0; i < 20; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_data", 32'(rsp_data), 32'h5A);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge sys_clk);
        end
        @(posedge sys_clk);
        #1;
        rsp_ready = 1'b1;
        drain(50);

`ifdef I2C_SEQ_TIMEOUT_EN
        e_never = 1'b1;
        send(2'd1, 8'h66, 8'h00, 1'b1, 1'b1);
        drain(400);
        e_never = 1'b0;
`endif

        // Reset mid-WAIT drops the pending response
        e_delay = 50;
        send(2'd1, 8'hC3, 8'h00, 1'b0, 1'b0);
        repeat (6) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        sb.delete();
        @(negedge sys_clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_start", 32'(i2c_start), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        e_delay = 2;
        send(2'd3, 8'h00, 8'h00, 1'b0, 1'b0);
        drain(50);

        repeat (3) @(posedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
